// File: rtl/design_12_out_buf.sv
// ============================================================================
//  Module   : design_12_out_buf
//  Brief    : Result FIFO with valid/ready output, drop counting and debug flags.
//             Optional parity per entry via DESIGN_12_OUT_BUF_PAR_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module design_12_out_buf #(
   parameter int W     = 12,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [W-1:0]               in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_data,
`ifdef DESIGN_12_OUT_BUF_PAR_EN
   output logic                       out_par,
`endif
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [CW-1:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
`ifdef DESIGN_12_OUT_BUF_PAR_EN
   localparam int MW = W + 1;
`else
   localparam int MW = W;
`endif
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [0:0] {
      ST_EMPTY    = 1'b0,
      ST_NONEMPTY = 1'b1
   } state_t;

   logic [MW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   state_t        state_q, state_d;

   logic          w_full, w_empty, w_push, w_pop, w_drop;
   logic [MW-1:0] w_wdata;
   logic [MW-1:0] w_head;

   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign w_pop   = out_valid & out_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign w_push  = in_valid & (!w_full | w_pop);
   assign w_drop  = in_valid & w_full & !w_pop;

`ifdef DESIGN_12_OUT_BUF_PAR_EN
   assign w_wdata = {^in_data, in_data};
`else
   assign w_wdata = in_data;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= w_wdata;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (w_push && !w_pop)      level_d = level_q + PTR_ONE;
         else if (w_pop && !w_push) level_d = level_q - PTR_ONE;
         if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
         end
      end
      state_d = (level_d == '0) ? ST_EMPTY : ST_NONEMPTY;
   end

   assign w_head    = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid = (state_q == ST_NONEMPTY);
   assign out_data  = w_head[W-1:0];
`ifdef DESIGN_12_OUT_BUF_PAR_EN
   assign out_par   = out_valid & w_head[W];
`endif
   assign level     = level_q;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_design_12_out_buf.sv
// ============================================================================
//  Module   : tb_design_12_out_buf
//  Brief    : Directed self-checking bench for design_12_out_buf.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_design_12_out_buf;

   logic        clk;
   logic        rst_n;
   logic        in_valid, flush, out_ready;
   logic [11:0] in_data;
   logic        out_valid, full, empty, overflow;
   logic [11:0] out_data;
   logic [2:0]  level;
   logic [7:0]  drop_cnt;
`ifdef DESIGN_12_OUT_BUF_PAR_EN
   logic        out_par;
   logic        out_par2;
`endif

   logic        in_valid2, flush2, out_ready2;
   logic [11:0] in_data2;
   logic        out_valid2, full2, empty2, overflow2;
   logic [11:0] out_data2;
   logic [2:0]  level2;
   logic [1:0]  drop_cnt2;

   int n_vec;
   int n_err;

   design_12_out_buf #(.W(12), .DEPTH(4), .CW(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef DESIGN_12_OUT_BUF_PAR_EN
      .out_par(out_par),
`endif
      .level(level), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   design_12_out_buf #(.W(12), .DEPTH(4), .CW(2)) u_dut_cw2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
      .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
`ifdef DESIGN_12_OUT_BUF_PAR_EN
      .out_par(out_par2),
`endif
      .level(level2), .full(full2), .empty(empty2), .overflow(overflow2), .drop_cnt(drop_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [11:0] d, input logic rdy);
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
   endtask

   // Fill main FIFO with four words base..base+3, consumer stalled.
   task automatic fill4(input logic [11:0] base);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, base + 12'(i), 1'b0);
         tick();
      end
      drive(1'b0, 12'h000, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; flush = 1'b0;
      drive(1'b0, 12'h000, 1'b0);
      in_valid2 = 1'b0; in_data2 = 12'h000; flush2 = 1'b0; out_ready2 = 1'b0;
      tick(); tick();

      check("rst_level",    32'(level), 32'd0);
      check("rst_empty",    32'(empty), 32'd1);
      check("rst_full",     32'(full), 32'd0);
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_dropcnt",  32'(drop_cnt), 32'd0);
`ifdef DESIGN_12_OUT_BUF_PAR_EN
      check("rst_par",      32'(out_par), 32'd0);
`endif
      rst_n = 1'b1;

      // Test 1: three pushes then drain
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 12'(i), 1'b0);
         tick();
         check("t1_level_up", 32'(level), 32'(i));
         check("t1_head",     32'(out_data), 32'h001);
      end
      drive(1'b0, 12'h000, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         check("t1_valid", 32'(out_valid), 32'd1);
         check("t1_data",  32'(out_data), 32'(i));
         tick();
         check("t1_level_dn", 32'(level), 32'(3 - i));
      end
      check("t1_empty", 32'(empty), 32'd1);
      check("t1_nvalid", 32'(out_valid), 32'd0);
      tick();
      check("empty_rdy_level", 32'(level), 32'd0);
      check("empty_rdy_empty", 32'(empty), 32'd1);

      // Test 2: six pushes into a depth-4 FIFO
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 12'h0A0 + 12'(i), 1'b0);
         tick();
         if (i == 3) check("t2_full4", 32'(full), 32'd1);
      end
      check("t2_dropcnt",  32'(drop_cnt), 32'd2);
      check("t2_overflow", 32'(overflow), 32'd1);
      check("t2_level",    32'(level), 32'd4);
      drive(1'b0, 12'h000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t2_data", 32'(out_data), 32'h0A0 + 32'(i));
         tick();
      end
      check("t2_empty", 32'(empty), 32'd1);
      drive(1'b0, 12'h000, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      check("t2_flush_dropcnt",  32'(drop_cnt), 32'd0);
      check("t2_flush_overflow", 32'(overflow), 32'd0);

      // Test 3: full FIFO, concurrent push/pop for three cycles
      fill4(12'h0B0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 12'h0C0 + 12'(i), 1'b1);
         check("t3_head", 32'(out_data), 32'h0B0 + 32'(i));
         tick();
         check("t3_level", 32'(level), 32'd4);
      end
      check("t3_nodrop", 32'(drop_cnt), 32'd0);
      drive(1'b0, 12'h000, 1'b1);
      check("t3_d0", 32'(out_data), 32'h0B3); tick();
      check("t3_d1", 32'(out_data), 32'h0C0); tick();
      check("t3_d2", 32'(out_data), 32'h0C1); tick();
      check("t3_d3", 32'(out_data), 32'h0C2); tick();
      check("t3_empty", 32'(empty), 32'd1);
      drive(1'b0, 12'h000, 1'b0);

      // Test 4: CW=2 drop counter saturation
      for (int i = 0; i < 14; i++) begin
         in_valid2 = 1'b1; in_data2 = 12'h100 + 12'(i);
         tick();
         if (i == 5) check("t4_cnt2", 32'(drop_cnt2), 32'd2);
         if (i == 6) check("t4_cnt3", 32'(drop_cnt2), 32'd3);
      end
      in_valid2 = 1'b0;
      check("t4_sat",   32'(drop_cnt2), 32'd3);
      check("t4_level", 32'(level2), 32'd4);
      out_ready2 = 1'b1;
      check("t4_head", 32'(out_data2), 32'h100);

      // Test 5a: flush with level 3 and a concurrent result
      fill4(12'h050);
      drive(1'b1, 12'h0EE, 1'b0); tick();
      drive(1'b0, 12'h000, 1'b1); tick();
      check("t5_pre_level", 32'(level), 32'd3);
      check("t5_pre_drop",  32'(drop_cnt), 32'd1);
      drive(1'b1, 12'h7FF, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      drive(1'b0, 12'h000, 1'b0);
      check("t5f_level",    32'(level), 32'd0);
      check("t5f_valid",    32'(out_valid), 32'd0);
      check("t5f_drop",     32'(drop_cnt), 32'd0);
      check("t5f_overflow", 32'(overflow), 32'd0);
      drive(1'b1, 12'h055, 1'b0); tick();
      drive(1'b0, 12'h000, 1'b1);
      check("t5f_next", 32'(out_data), 32'h055);
      tick();
      check("t5f_drained", 32'(empty), 32'd1);

      // Test 5b: same scenario with reset instead of flush
      fill4(12'h060);
      drive(1'b1, 12'h0EE, 1'b0); tick();
      drive(1'b0, 12'h000, 1'b1); tick();
      drive(1'b1, 12'h7FF, 1'b0);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      drive(1'b0, 12'h000, 1'b0);
      check("t5r_level", 32'(level), 32'd0);
      check("t5r_valid", 32'(out_valid), 32'd0);
      check("t5r_drop",  32'(drop_cnt), 32'd0);
      drive(1'b1, 12'h066, 1'b0); tick();
      drive(1'b0, 12'h000, 1'b1);
      check("t5r_next", 32'(out_data), 32'h066);
      tick();
      drive(1'b0, 12'h000, 1'b0);

`ifdef DESIGN_12_OUT_BUF_PAR_EN
      // Test 6: parity of head entry
      drive(1'b1, 12'h007, 1'b0); tick();
      drive(1'b1, 12'h003, 1'b0); tick();
      drive(1'b0, 12'h000, 1'b1);
      check("t6_par1", 32'(out_par), 32'd1);
      tick();
      check("t6_data", 32'(out_data), 32'h003);
      check("t6_par0", 32'(out_par), 32'd0);
      tick();
      check("t6_par_empty", 32'(out_par), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
